alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 run  input  1  level; high in IDLE starts execution at pc=0.
REQ-003 imem_addr  output  4  program ROM address, registered.
REQ-004 imem_data  input  8  ROM word, valid one cycle after imem_addr changes; [7:4] instr opcode, [3:0] imm.
REQ-005 alu_opcode  output  4  ALU opcode; alu_a  output  4  operand A (=acc); alu_b  output  4  operand B (=breg).
REQ-006 alu_c  input  4  ALU result; alu_zf  input  1  result zero; alu_cf  input  1  carry/borrow/shift-out.
REQ-007 acc  output  4  accumulator; zf_q  output  1  registered zero flag; cf_q  output  1  registered carry flag.
REQ-008 busy  output  1  high in any state except IDLE and HALT; halted  output  1  high in HALT.

Function
REQ-009 States SHALL be IDLE, FETCH, DECODE, EXEC, WRITE, HALT.
REQ-010 IDLE: pc=0; run=1 -> FETCH; else stay.
REQ-011 FETCH: imem_addr<=pc -> DECODE; DECODE: ir<=imem_data -> EXEC.
REQ-012 Instr opcodes 0x0-0x7 SHALL issue ALU ops AND, OR, XOR, NOT, INC, DEC, SHL, SHR in that order; EXEC drives alu_opcode/alu_a/alu_b -> WRITE; WRITE latches acc<=alu_c, zf_q<=alu_zf, cf_q<=alu_cf, pc<=pc+1 -> FETCH (4 cycles per ALU instruction).
REQ-013 Non-ALU opcodes SHALL complete in EXEC (3 cycles) -> FETCH: 0x8 LDA acc<=imm; 0x9 LDB breg<=imm; 0xA JMP pc<=imm; 0xB JZ pc<=imm if zf_q else pc+1; 0xC JC pc<=imm if cf_q else pc+1; 0xD and 0xE NOP; 0xF HALT -> HALT; non-jumps pc<=pc+1.
REQ-014 LDA, LDB, jumps and NOP SHALL NOT change zf_q/cf_q.
REQ-015 pc SHALL be 4 bits and wrap 15->0 on increment.
REQ-016 Outside EXEC, alu_opcode SHALL hold its last value; alu_a/alu_b always mirror acc/breg.
REQ-017 run deasserted while busy SHALL be ignored; execution continues until HALT.
REQ-018 HALT: stay while run=1; run=0 -> IDLE (acc, breg, flags retained).

Reset
REQ-019 rst_n low SHALL asynchronously force state=IDLE, pc=0, ir=0, acc=0, breg=0, zf_q=0, cf_q=0, imem_addr=0, alu_opcode=0, busy=0, halted=0, including mid-instruction.
REQ-020 Outputs SHALL follow the reset values in REQ-019 while rst_n is low; first FETCH occurs no earlier than the first rising edge after release with run=1.

Configuration
REQ-021 Macro ALU_SEQUENCER_STEP_EN SHALL compile in single-step mode: extra port step  input  1; after WRITE or non-ALU EXEC the FSM enters state STEP_WAIT and advances to FETCH only on a clk edge with step=1; HALT is unaffected.
REQ-022 Without ALU_SEQUENCER_STEP_EN, the step port and STEP_WAIT SHALL not exist and execution is free-running per REQ-012/013.

Structure
REQ-023 Shared package cpu_pkg SHALL hold ALU opcode constants, instruction opcode constants (0x0-0xF), and the state enumeration.
REQ-024 Sub-module alu_seq_decode (combinational: ir[7:4] -> alu_opcode, is_alu, is_jump, jump condition, is_halt) SHALL be instantiated once.

Verification
REQ-025 Program {LDA 5, LDB 3, AND, HALT}, run=1 -> acc=1, zf_q=0, cf_q=0, halted=1 after 3+3+4+3 cycles.
REQ-026 {LDA 0xF, INC, JC 6, ..., 6:HALT} -> acc=0, zf_q=1, cf_q=1, pc reaches 6; skipped words never fetched.
REQ-027 {LDA 0, DEC, HALT} -> acc=0xF, cf_q=1, zf_q=0; {LDA 8, SHL} -> acc=0, cf_q=1, zf_q=1.
REQ-028 JMP 0xF with word 0xF = NOP, then word 0 = HALT -> pc wraps 15->0, halted=1.
REQ-029 rst_n pulsed low during WRITE of INC -> all outputs at reset values within the same cycle, acc not updated; run=1 afterwards restarts at pc=0.
REQ-030 With ALU_SEQUENCER_STEP_EN: step held 0 after LDA 5 -> FSM parks in STEP_WAIT, imem_addr stable; one-cycle step=1 -> exactly one further instruction executes.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode constants, FSM state and jump-condition types for alu_sequencer.
package cpu_pkg;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_XOR = 4'h2;
  localparam logic [3:0] ALU_NOT = 4'h3;
  localparam logic [3:0] ALU_INC = 4'h4;
  localparam logic [3:0] ALU_DEC = 4'h5;
  localparam logic [3:0] ALU_SHL = 4'h6;
  localparam logic [3:0] ALU_SHR = 4'h7;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_XOR  = 4'h2;
  localparam logic [3:0] OP_NOT  = 4'h3;
  localparam logic [3:0] OP_INC  = 4'h4;
  localparam logic [3:0] OP_DEC  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LDA  = 4'h8;
  localparam logic [3:0] OP_LDB  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_NOP0 = 4'hD;
  localparam logic [3:0] OP_NOP1 = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

`ifdef ALU_SEQUENCER_STEP_EN
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WRITE, HALT, STEP_WAIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WRITE, HALT} state_t;
`endif

  typedef enum logic [1:0] {JC_ALWAYS, JC_ZERO, JC_CARRY} jcond_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - program ROM and external ALU bus between the sequencer and its environment.
interface alu_sequencer_if;
  logic [3:0] imem_addr;
  logic [7:0] imem_data;
  logic [3:0] alu_opcode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_c;
  logic       alu_zf;
  logic       alu_cf;

  modport master (
    output imem_addr, alu_opcode, alu_a, alu_b,
    input  imem_data, alu_c, alu_zf, alu_cf
  );

  modport slave (
    input  imem_addr, alu_opcode, alu_a, alu_b,
    output imem_data, alu_c, alu_zf, alu_cf
  );
endinterface

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - combinational instruction decode from the instruction opcode nibble.
module alu_seq_decode
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  output logic [3:0] alu_op,
  output logic       is_alu,
  output logic       is_jump,
  output jcond_t     jcond,
  output logic       is_halt,
  output logic       is_lda,
  output logic       is_ldb
);
  always_comb begin
    alu_op  = ALU_AND;
    is_alu  = 1'b0;
    is_jump = 1'b0;
    jcond   = JC_ALWAYS;
    is_halt = 1'b0;
    is_lda  = 1'b0;
    is_ldb  = 1'b0;
    case (op)
      OP_AND:  begin is_alu = 1'b1; alu_op = ALU_AND; end
      OP_OR:   begin is_alu = 1'b1; alu_op = ALU_OR;  end
      OP_XOR:  begin is_alu = 1'b1; alu_op = ALU_XOR; end
      OP_NOT:  begin is_alu = 1'b1; alu_op = ALU_NOT; end
      OP_INC:  begin is_alu = 1'b1; alu_op = ALU_INC; end
      OP_DEC:  begin is_alu = 1'b1; alu_op = ALU_DEC; end
      OP_SHL:  begin is_alu = 1'b1; alu_op = ALU_SHL; end
      OP_SHR:  begin is_alu = 1'b1; alu_op = ALU_SHR; end
      OP_LDA:  is_lda = 1'b1;
      OP_LDB:  is_ldb = 1'b1;
      OP_JMP:  begin is_jump = 1'b1; jcond = JC_ALWAYS; end
      OP_JZ:   begin is_jump = 1'b1; jcond = JC_ZERO;   end
      OP_JC:   begin is_jump = 1'b1; jcond = JC_CARRY;  end
      OP_NOP0, OP_NOP1: ;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle sequencer driving an external 4-bit ALU from a 16-word program ROM.
// Define ALU_SEQUENCER_STEP_EN for single-step mode (adds the step port and the STEP_WAIT state).
module alu_sequencer
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
`ifdef ALU_SEQUENCER_STEP_EN
  input  logic       step,
`endif
  alu_sequencer_if.master bus,
  output logic [3:0] acc,
  output logic       zf_q,
  output logic       cf_q,
  output logic       busy,
  output logic       halted
);
  state_t     state;
  logic [3:0] pc;
  logic [7:0] ir;
  logic [3:0] breg;
  logic [3:0] imem_addr_q;
  logic [3:0] alu_opcode_q;

  logic [3:0] dec_alu_op;
  logic       dec_is_alu;
  logic       dec_is_jump;
  jcond_t     dec_jcond;
  logic       dec_is_halt;
  logic       dec_is_lda;
  logic       dec_is_ldb;
  logic       jump_taken;
  logic [3:0] pc_inc;

`ifdef ALU_SEQUENCER_STEP_EN
  localparam state_t AFTER_INSTR = STEP_WAIT;
`else
  localparam state_t AFTER_INSTR = FETCH;
`endif

  alu_seq_decode u_decode (
    .op      (ir[7:4]),
    .alu_op  (dec_alu_op),
    .is_alu  (dec_is_alu),
    .is_jump (dec_is_jump),
    .jcond   (dec_jcond),
    .is_halt (dec_is_halt),
    .is_lda  (dec_is_lda),
    .is_ldb  (dec_is_ldb)
  );

  assign bus.imem_addr  = imem_addr_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_a      = acc;
  assign bus.alu_b      = breg;

  // 4-bit pc wraps 15 -> 0 naturally
  assign pc_inc = pc + 4'd1;

  always_comb begin
    case (dec_jcond)
      JC_ZERO:  jump_taken = zf_q;
      JC_CARRY: jump_taken = cf_q;
      default:  jump_taken = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= 4'd0;
      ir           <= 8'd0;
      acc          <= 4'd0;
      breg         <= 4'd0;
      zf_q         <= 1'b0;
      cf_q         <= 1'b0;
      imem_addr_q  <= 4'd0;
      alu_opcode_q <= 4'd0;
      busy         <= 1'b0;
      halted       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pc <= 4'd0;
          if (run) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          imem_addr_q <= pc;
          state       <= DECODE;
        end
        DECODE: begin
          ir    <= bus.imem_data;
          state <= EXEC;
        end
        EXEC: begin
          if (dec_is_alu) begin
            alu_opcode_q <= dec_alu_op;
            state        <= WRITE;
          end else if (dec_is_halt) begin
            state  <= HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            // LDA/LDB/jumps/NOP retire here and leave the flags untouched
            if (dec_is_lda) acc  <= ir[3:0];
            if (dec_is_ldb) breg <= ir[3:0];
            pc    <= (dec_is_jump && jump_taken) ? ir[3:0] : pc_inc;
            state <= AFTER_INSTR;
          end
        end
        WRITE: begin
          acc   <= bus.alu_c;
          zf_q  <= bus.alu_zf;
          cf_q  <= bus.alu_cf;
          pc    <= pc_inc;
          state <= AFTER_INSTR;
        end
        HALT: begin
          if (!run) begin
            state  <= IDLE;
            halted <= 1'b0;
          end
        end
`ifdef ALU_SEQUENCER_STEP_EN
        STEP_WAIT: begin
          if (step) state <= FETCH;
        end
`endif
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench with ROM and ALU models for alu_sequencer.
module tb_alu_sequencer;
  logic       clk;
  logic       rst_n;
  logic       run;
`ifdef ALU_SEQUENCER_STEP_EN
  logic       step;
`endif
  logic [3:0] acc;
  logic       zf_q;
  logic       cf_q;
  logic       busy;
  logic       halted;

  logic [7:0] rom [16];
  logic [4:0] alu_res;
  int         total;
  int         bad;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
`ifdef ALU_SEQUENCER_STEP_EN
    .step   (step),
`endif
    .bus    (bus),
    .acc    (acc),
    .zf_q   (zf_q),
    .cf_q   (cf_q),
    .busy   (busy),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.imem_data = rom[bus.imem_addr];

  // reference ALU: bit 4 is carry / borrow / shifted-out bit
  always_comb begin
    alu_res = 5'd0;
    case (bus.alu_opcode)
      4'h0: alu_res = {1'b0, bus.alu_a & bus.alu_b};
      4'h1: alu_res = {1'b0, bus.alu_a | bus.alu_b};
      4'h2: alu_res = {1'b0, bus.alu_a ^ bus.alu_b};
      4'h3: alu_res = {1'b0, ~bus.alu_a};
      4'h4: alu_res = {1'b0, bus.alu_a} + 5'd1;
      4'h5: alu_res = {1'b0, bus.alu_a} - 5'd1;
      4'h6: alu_res = {bus.alu_a, 1'b0};
      4'h7: alu_res = {bus.alu_a[0], 1'b0, bus.alu_a[3:1]};
      default: alu_res = 5'd0;
    endcase
  end
  assign bus.alu_c  = alu_res[3:0];
  assign bus.alu_cf = alu_res[4];
  assign bus.alu_zf = (alu_res[3:0] == 4'd0);

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'hD0;
  endtask

  task automatic do_reset();
    run   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input int budget, output bit ok, output logic [15:0] seen);
    ok   = 1'b0;
    seen = 16'd0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      seen[bus.imem_addr] = 1'b1;
      if (halted) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    clear_rom();
    repeat (2) @(posedge clk);
    #1;
    total++; if (acc !== 4'd0) begin bad++; $display("FAIL reset_acc got=%h exp=0", acc); end
    total++; if ({zf_q, cf_q} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {zf_q, cf_q}); end
    total++; if ({busy, halted} !== 2'b00) begin bad++; $display("FAIL reset_status got=%b exp=00", {busy, halted}); end
    total++; if (bus.imem_addr !== 4'd0) begin bad++; $display("FAIL reset_imem_addr got=%h exp=0", bus.imem_addr); end
    total++; if (bus.alu_opcode !== 4'd0) begin bad++; $display("FAIL reset_alu_opcode got=%h exp=0", bus.alu_opcode); end
    total++; if (bus.alu_b !== 4'd0) begin bad++; $display("FAIL reset_breg got=%h exp=0", bus.alu_b); end
  endtask

  task automatic test_and_timing();
    clear_rom();
    rom[0] = 8'h85; rom[1] = 8'h93; rom[2] = 8'h00; rom[3] = 8'hF0;
    do_reset();
    run = 1'b1;
    repeat (13) @(posedge clk);
    #1;
    total++; if ({busy, halted} !== 2'b10) begin bad++; $display("FAIL and_before_halt got=%b exp=10", {busy, halted}); end
    @(posedge clk);
    #1;
    total++; if ({busy, halted} !== 2'b01) begin bad++; $display("FAIL and_halt_cycle got=%b exp=01", {busy, halted}); end
    total++; if (acc !== 4'h1) begin bad++; $display("FAIL and_acc got=%h exp=1", acc); end
    total++; if ({zf_q, cf_q} !== 2'b00) begin bad++; $display("FAIL and_flags got=%b exp=00", {zf_q, cf_q}); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_hold got=%b exp=1", halted); end
    run = 1'b0;
    @(posedge clk);
    #1;
    total++; if ({busy, halted} !== 2'b00) begin bad++; $display("FAIL halt_to_idle got=%b exp=00", {busy, halted}); end
    total++; if (acc !== 4'h1 || bus.alu_b !== 4'h3) begin bad++; $display("FAIL idle_retain got=%h/%h exp=1/3", acc, bus.alu_b); end
  endtask

  task automatic test_jc_skip();
    bit ok;
    logic [15:0] seen;
    clear_rom();
    rom[0] = 8'h8F; rom[1] = 8'h40; rom[2] = 8'hC6;
    rom[3] = 8'h85; rom[4] = 8'h85; rom[5] = 8'h85; rom[6] = 8'hF0;
    do_reset();
    run = 1'b1;
    wait_halt(60, ok, seen);
    total++; if (!ok) begin bad++; $display("FAIL jc_timeout got=0 exp=halted"); end
    total++; if (acc !== 4'h0) begin bad++; $display("FAIL jc_acc got=%h exp=0", acc); end
    total++; if ({zf_q, cf_q} !== 2'b11) begin bad++; $display("FAIL jc_flags got=%b exp=11", {zf_q, cf_q}); end
    total++; if (bus.imem_addr !== 4'h6) begin bad++; $display("FAIL jc_pc got=%h exp=6", bus.imem_addr); end
    total++; if ((seen & 16'h0038) !== 16'h0) begin bad++; $display("FAIL jc_skipped_fetch got=%h exp=0", seen & 16'h0038); end
    run = 1'b0;
  endtask

  task automatic test_jz_flags_kept();
    bit ok;
    logic [15:0] seen;
    clear_rom();
    rom[0] = 8'h80; rom[1] = 8'h00; rom[2] = 8'hB4; rom[3] = 8'h81;
    rom[4] = 8'h83; rom[5] = 8'hB7; rom[6] = 8'h81; rom[7] = 8'hF0;
    do_reset();
    run = 1'b1;
    wait_halt(60, ok, seen);
    total++; if (!ok) begin bad++; $display("FAIL jz_timeout got=0 exp=halted"); end
    total++; if (acc !== 4'h3) begin bad++; $display("FAIL jz_acc got=%h exp=3", acc); end
    total++; if ({zf_q, cf_q} !== 2'b10) begin bad++; $display("FAIL jz_flags got=%b exp=10", {zf_q, cf_q}); end
    total++; if ((seen & 16'h0048) !== 16'h0) begin bad++; $display("FAIL jz_skipped_fetch got=%h exp=0", seen & 16'h0048); end
    run = 1'b0;
  endtask

  task automatic test_dec_run_pulse();
    bit ok;
    logic [15:0] seen;
    clear_rom();
    rom[0] = 8'h80; rom[1] = 8'h50; rom[2] = 8'hF0;
    do_reset();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_halt(40, ok, seen);
    total++; if (!ok) begin bad++; $display("FAIL dec_timeout got=0 exp=halted"); end
    total++; if (acc !== 4'hF) begin bad++; $display("FAIL dec_acc got=%h exp=f", acc); end
    total++; if ({zf_q, cf_q} !== 2'b01) begin bad++; $display("FAIL dec_flags got=%b exp=01", {zf_q, cf_q}); end
  endtask

  task automatic test_shl_and_logic();
    bit ok;
    logic [15:0] seen;
    clear_rom();
    rom[0] = 8'h88; rom[1] = 8'h60; rom[2] = 8'hF0;
    do_reset();
    run = 1'b1;
    wait_halt(40, ok, seen);
    total++; if (!ok || acc !== 4'h0 || {zf_q, cf_q} !== 2'b11) begin
      bad++; $display("FAIL shl_result got=%b/%h/%b exp=1/0/11", ok, acc, {zf_q, cf_q});
    end
    run = 1'b0;
    // A=0xA, B=6: OR->E, XOR->8, NOT->7, SHR->3 with carry out 1
    clear_rom();
    rom[0] = 8'h8A; rom[1] = 8'h96; rom[2] = 8'h10; rom[3] = 8'h20;
    rom[4] = 8'h30; rom[5] = 8'h70; rom[6] = 8'hF0;
    do_reset();
    run = 1'b1;
    wait_halt(60, ok, seen);
    total++; if (!ok || acc !== 4'h3 || {zf_q, cf_q} !== 2'b01) begin
      bad++; $display("FAIL logic_chain got=%b/%h/%b exp=1/3/01", ok, acc, {zf_q, cf_q});
    end
    total++; if (bus.alu_opcode !== 4'h7) begin bad++; $display("FAIL alu_opcode_hold got=%h exp=7", bus.alu_opcode); end
    run = 1'b0;
  endtask

  task automatic test_pc_wrap();
    bit ok;
    bit hit;
    logic [15:0] seen;
    clear_rom();
    rom[0] = 8'hAF;
    do_reset();
    run = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (bus.imem_addr == 4'hF) hit = 1'b1;
    end
    total++; if (!hit) begin bad++; $display("FAIL wrap_reach_f got=0 exp=1"); end
    rom[0] = 8'hF0;
    wait_halt(40, ok, seen);
    total++; if (!ok || bus.imem_addr !== 4'h0) begin bad++; $display("FAIL wrap_halt got=%b/%h exp=1/0", ok, bus.imem_addr); end
    total++; if ((seen & 16'h7FFE) !== 16'h0) begin bad++; $display("FAIL wrap_stray_fetch got=%h exp=0", seen & 16'h7FFE); end
    run = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    logic [15:0] seen;
    clear_rom();
    rom[0] = 8'h85; rom[1] = 8'h40; rom[2] = 8'hF0;
    do_reset();
    run = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    total++; if (bus.alu_opcode !== 4'h4 || acc !== 4'h5) begin
      bad++; $display("FAIL pre_reset_state got=%h/%h exp=4/5", bus.alu_opcode, acc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (acc !== 4'h0 || {zf_q, cf_q, busy, halted} !== 4'b0000) begin
      bad++; $display("FAIL mid_reset_outputs got=%h/%b exp=0/0000", acc, {zf_q, cf_q, busy, halted});
    end
    total++; if (bus.imem_addr !== 4'h0 || bus.alu_opcode !== 4'h0) begin
      bad++; $display("FAIL mid_reset_bus got=%h/%h exp=0/0", bus.imem_addr, bus.alu_opcode);
    end
    @(posedge clk);
    @(negedge clk);
    total++; if (acc !== 4'h0) begin bad++; $display("FAIL mid_reset_no_write got=%h exp=0", acc); end
    rst_n = 1'b1;
    wait_halt(40, ok, seen);
    total++; if (!ok || acc !== 4'h6 || !seen[0]) begin
      bad++; $display("FAIL restart got=%b/%h/%b exp=1/6/1", ok, acc, seen[0]);
    end
    run = 1'b0;
  endtask

`ifdef ALU_SEQUENCER_STEP_EN
  task automatic test_step();
    bit ok;
    logic [15:0] seen;
    clear_rom();
    rom[0] = 8'h85; rom[1] = 8'h40; rom[2] = 8'hF0;
    step = 1'b0;
    do_reset();
    run = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (acc !== 4'h5 || busy !== 1'b1 || bus.imem_addr !== 4'h0) begin
      bad++; $display("FAIL step_park got=%h/%b/%h exp=5/1/0", acc, busy, bus.imem_addr);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (acc !== 4'h6 || halted !== 1'b0 || bus.imem_addr !== 4'h1) begin
      bad++; $display("FAIL step_one got=%h/%b/%h exp=6/0/1", acc, halted, bus.imem_addr);
    end
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_halt(10, ok, seen);
    total++; if (!ok) begin bad++; $display("FAIL step_halt got=0 exp=1"); end
    run = 1'b0;
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
`ifdef ALU_SEQUENCER_STEP_EN
    step  = 1'b0;
`endif
    test_reset();
`ifdef ALU_SEQUENCER_STEP_EN
    test_step();
`else
    test_and_timing();
    test_jc_skip();
    test_jz_flags_kept();
    test_dec_run_pulse();
    test_shl_and_logic();
    test_pc_wrap();
    test_reset_mid_write();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
